// File: rtl/fetch_ctrl.sv
// fetch_ctrl: owns the PC, fetches from imem and buffers {pc, instr} pairs
// in a 2-entry FIFO towards decode, with branch flush, halt and fault states.
module fetch_ctrl #(
  parameter int          IMEM_SIZE  = 1024,
  parameter logic [63:0] RESET_PC   = 64'h0,
  parameter logic [31:0] HALT_INSTR = 32'hD4400000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [63:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        branch_taken,
  input  logic [63:0] branch_target,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [63:0] out_pc,
  output logic        halted,
  output logic        fault
);
  typedef enum logic [1:0] {IDLE, FETCH, HALT, FAULT} state_t;
  localparam logic [63:0] LIMIT = 64'(IMEM_SIZE) * 64'd4;
  state_t      state;
  logic [63:0] pc;
  logic [63:0] q_pc [2];
  logic [31:0] q_instr [2];
  logic        rd_ptr, wr_ptr;
  logic [1:0]  count;
  logic        flush, pop, bad, push;
  always_comb begin
    flush = branch_taken && state != IDLE;
    pop   = out_valid && out_ready && !flush;
    bad   = pc[1:0] != 2'b00 || pc >= LIMIT;
    push  = !flush && state == FETCH && !bad && (count != 2'd2 || pop);
  end
  assign imem_addr = pc;
  assign out_valid = count != 2'd0;
  assign out_instr = out_valid ? q_instr[rd_ptr] : 32'h0;
  assign out_pc    = out_valid ? q_pc[rd_ptr] : 64'h0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      q_pc[0]    <= '0;
      q_pc[1]    <= '0;
      q_instr[0] <= '0;
      q_instr[1] <= '0;
      rd_ptr     <= 1'b0;
      wr_ptr     <= 1'b0;
      count      <= 2'd0;
      halted     <= 1'b0;
      fault      <= 1'b0;
    end else if (flush) begin
      state  <= FETCH;
      pc     <= branch_target;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
      halted <= 1'b0;
      fault  <= 1'b0;
    end else begin
      case (state)
        IDLE:  state <= start ? FETCH : IDLE;
        FETCH: begin
          if (bad) begin
            state <= FAULT;
            fault <= 1'b1;
          end else if (push) begin
            pc <= pc + 64'd4;
            if (imem_instr == HALT_INSTR) begin
              state  <= HALT;
              halted <= 1'b1;
            end
          end
        end
        default: state <= state;
      endcase
      if (push) begin
        q_pc[wr_ptr]    <= pc;
        q_instr[wr_ptr] <= imem_instr;
        wr_ptr          <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: scoreboard bench; expected {pc, instr} pairs are queued by
// each scenario and consumed by a monitor on every accepted handshake.
module tb_fetch_ctrl;
  localparam logic [31:0] HLT = 32'hD4400000;
  localparam logic [31:0] I1 = 32'h8B010000, I2 = 32'h8B020000, I3 = 32'h8B030000;
  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [63:0] imem_addr;
  logic [31:0] imem_instr;
  logic        branch_taken = 1'b0;
  logic [63:0] branch_target = 64'h0;
  logic        out_valid, out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [63:0] out_pc;
  logic        halted, fault;
  logic [31:0] mem [1024];
  logic [95:0] exp_q [$];
  int          tests = 0, fails = 0;

  fetch_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .imem_addr(imem_addr),
    .imem_instr(imem_instr), .branch_taken(branch_taken),
    .branch_target(branch_target), .out_valid(out_valid),
    .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
    .halted(halted), .fault(fault)
  );

  always #5 clk = ~clk;
  assign imem_instr = mem[imem_addr[11:2]];

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL pop_unexpected: got pc=%h instr=%h, required no output", out_pc, out_instr);
      end else begin
        if ({out_pc, out_instr} !== exp_q[0]) begin
          fails++;
          $display("FAIL pop_order: got pc=%h instr=%h, required pc=%h instr=%h",
                   out_pc, out_instr, exp_q[0][95:32], exp_q[0][31:0]);
        end
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    out_ready = 1'b0; start = 1'b0; branch_taken = 1'b0;
    exp_q.delete();
    #1 rst_n = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    cyc(1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  task automatic branch(input logic [63:0] t);
    branch_taken = 1'b1; branch_target = t;
    cyc(1);
    branch_taken = 1'b0;
  endtask

  task automatic push_prog(input logic [63:0] base);
    for (int i = 0; i < 4; i++)
      exp_q.push_back({base + 64'(4 * i), mem[base[11:2] + 10'(i)]});
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      cyc(1);
      n++;
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL %s_drain: %0d entries still expected, required 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    tests++;
    if ({out_valid, out_instr, out_pc, halted, fault, imem_addr} !== '0) begin
      fails++;
      $display("FAIL reset: got v=%b i=%h p=%h h=%b f=%b a=%h, required all 0",
               out_valid, out_instr, out_pc, halted, fault, imem_addr);
    end
  endtask

  task automatic test_stream();
    do_reset();
    out_ready = 1'b1;
    push_prog(64'h0);
    pulse_start();
    tests++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL stream_latency: out_valid=%b one cycle after start, required 0", out_valid);
    end
    cyc(1);
    tests++;
    if (out_valid !== 1'b1 || out_pc !== 64'h0) begin
      fails++;
      $display("FAIL stream_first: v=%b pc=%h, required v=1 pc=0", out_valid, out_pc);
    end
    drain("stream");
    tests++;
    if (halted !== 1'b1 || imem_addr !== 64'h10 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL stream_halt: h=%b addr=%h v=%b, required h=1 addr=10 v=0", halted, imem_addr, out_valid);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    push_prog(64'h0);
    pulse_start();
    cyc(4);
    tests++;
    if (out_valid !== 1'b1 || out_pc !== 64'h0 || out_instr !== I1 || imem_addr !== 64'h8) begin
      fails++;
      $display("FAIL bp_full: v=%b pc=%h i=%h addr=%h, required v=1 pc=0 i=%h addr=8",
               out_valid, out_pc, out_instr, imem_addr, I1);
    end
    out_ready = 1'b1;
    drain("bp");
    tests++;
    if (halted !== 1'b1) begin
      fails++;
      $display("FAIL bp_halt: halted=%b, required 1", halted);
    end
  endtask

  task automatic test_branch_flush();
    do_reset();
    pulse_start();
    cyc(3);
    exp_q.delete();
    for (int i = 0; i < 3; i++)
      exp_q.push_back({64'h40 + 64'(4 * i), mem[16 + i]});
    branch(64'h40);
    tests++;
    if (out_valid !== 1'b0 || imem_addr !== 64'h40) begin
      fails++;
      $display("FAIL br_flush: v=%b addr=%h, required v=0 addr=40", out_valid, imem_addr);
    end
    cyc(1);
    tests++;
    if (out_valid !== 1'b1 || out_pc !== 64'h40) begin
      fails++;
      $display("FAIL br_target: v=%b pc=%h, required v=1 pc=40", out_valid, out_pc);
    end
    out_ready = 1'b1;
    drain("br");
  endtask

  task automatic test_fault_end();
    do_reset();
    out_ready = 1'b1;
    exp_q.push_back({64'hFFC, I1});
    pulse_start();
    branch(64'hFFC);
    cyc(4);
    drain("end");
    tests++;
    if (fault !== 1'b1 || imem_addr !== 64'h1000 || out_valid !== 1'b0 || halted !== 1'b0) begin
      fails++;
      $display("FAIL end_fault: f=%b addr=%h v=%b h=%b, required f=1 addr=1000 v=0 h=0",
               fault, imem_addr, out_valid, halted);
    end
    push_prog(64'h0);
    branch(64'h0);
    tests++;
    if (fault !== 1'b0) begin
      fails++;
      $display("FAIL end_clear: fault=%b, required 0", fault);
    end
    drain("resume");
  endtask

  task automatic test_misaligned();
    branch(64'h6);
    cyc(3);
    tests++;
    if (fault !== 1'b1 || out_valid !== 1'b0 || imem_addr !== 64'h6 || halted !== 1'b0) begin
      fails++;
      $display("FAIL misalign: f=%b v=%b addr=%h h=%b, required f=1 v=0 addr=6 h=0",
               fault, out_valid, imem_addr, halted);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    pulse_start();
    cyc(3);
    tests++;
    if (out_valid !== 1'b1 || imem_addr !== 64'h8) begin
      fails++;
      $display("FAIL ar_pre: v=%b addr=%h, required v=1 addr=8", out_valid, imem_addr);
    end
    #1 rst_n = 1'b0;
    #1;
    tests++;
    if ({out_valid, out_instr, out_pc, halted, fault, imem_addr} !== '0) begin
      fails++;
      $display("FAIL ar_async: v=%b i=%h p=%h h=%b f=%b a=%h, required all 0",
               out_valid, out_instr, out_pc, halted, fault, imem_addr);
    end
    cyc(1);
    rst_n = 1'b1;
    out_ready = 1'b1;
    cyc(5);
    tests++;
    if (out_valid !== 1'b0 || imem_addr !== 64'h0) begin
      fails++;
      $display("FAIL ar_idle: v=%b addr=%h, required v=0 addr=0", out_valid, imem_addr);
    end
    push_prog(64'h0);
    pulse_start();
    drain("ar");
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    mem[0] = I1; mem[1] = I2; mem[2] = I3; mem[3] = HLT;
    mem[16] = 32'h8B0A0000; mem[17] = 32'h8B0B0000; mem[18] = HLT;
    mem[1023] = I1;
    #3;
    test_reset();
    rst_n = 1'b1;
    test_stream();
    test_backpressure();
    test_branch_flush();
    test_fault_end();
    test_misaligned();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, required completion");
    $fatal(1);
  end
endmodule
